// File: rtl/forward_ctrl.sv
// forward_ctrl: forwarding and load-use hazard controller for the pipelined core.
//
// Tracks the destination tag, valid and load flags of the DEPTH in-flight stages
// (stage 1 = X, 2 = M, 3 = W, ...). For the decode-stage instruction it produces a
// bypass select per source operand (0 = register file, k = forward from stage k,
// youngest writer wins) and a load-use stall when a stage-1 load feeds either operand.
// A saturating stall counter is kept for performance debug.
//
// Ports:
//   clock, reset      rising-edge clock, asynchronous active-high reset
//   flush             synchronous invalidate of every tracked stage
//   dec_*             decode-stage instruction: valid, destination, write enable,
//                     load flag, two source registers and their read enables
//   fwd_sel_a/b       per-operand bypass select (combinational from decode inputs)
//   load_use_stall    hold fetch/decode and inject a bubble into stage 1
//   stall_count       saturating count of stall cycles
module forward_ctrl #(
  parameter int unsigned REG_W = 5,
  parameter int unsigned DEPTH = 3,
  parameter int unsigned SEL_W = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             dec_valid,
  input  logic [REG_W-1:0] dec_rd,
  input  logic             dec_wr_en,
  input  logic             dec_is_load,
  input  logic [REG_W-1:0] dec_rs_a,
  input  logic [REG_W-1:0] dec_rs_b,
  input  logic             dec_use_a,
  input  logic             dec_use_b,
  output logic [SEL_W-1:0] fwd_sel_a,
  output logic [SEL_W-1:0] fwd_sel_b,
  output logic             load_use_stall,
  output logic [CNT_W-1:0] stall_count
);

  // Per-stage state, index k is pipeline stage k.
  logic [DEPTH:1]   vld_q, vld_d;
  logic [DEPTH:1]   ld_q, ld_d;
  logic [REG_W-1:0] rd_q [1:DEPTH];
  logic [REG_W-1:0] rd_d [1:DEPTH];
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [DEPTH:1]   match_a, match_b;
  logic [SEL_W-1:0] sel_a, sel_b;
  logic             stall;

  // Operand match and priority select.
  always_comb begin
    match_a = '0;
    match_b = '0;
    for (int unsigned k = 1; k <= DEPTH; k++) begin
      match_a[k] = vld_q[k] & (rd_q[k] == dec_rs_a) & dec_use_a & dec_valid &
                   (dec_rs_a != '0);
      match_b[k] = vld_q[k] & (rd_q[k] == dec_rs_b) & dec_use_b & dec_valid &
                   (dec_rs_b != '0);
    end
    // Scan oldest to youngest so the youngest matching stage is the last to write.
    sel_a = '0;
    sel_b = '0;
    for (int unsigned k = DEPTH; k >= 1; k--) begin
      if (match_a[k]) sel_a = SEL_W'(k);
      if (match_b[k]) sel_b = SEL_W'(k);
    end
    // A load in stage 1 has no result yet; the select still reports 1 but is ignored.
    stall = ld_q[1] & (match_a[1] | match_b[1]);
  end

  // Tag pipeline shift and stall counter.
  always_comb begin
    vld_d    = '0;
    ld_d     = '0;
    rd_d     = rd_q;
    vld_d[1] = dec_valid & dec_wr_en & (dec_rd != '0) & ~stall;
    ld_d[1]  = dec_is_load;
    rd_d[1]  = dec_rd;
    for (int unsigned k = 2; k <= DEPTH; k++) begin
      vld_d[k] = vld_q[k-1];
      ld_d[k]  = ld_q[k-1];
      rd_d[k]  = rd_q[k-1];
    end
    if (flush) begin
      vld_d = '0;
      ld_d  = '0;
    end

    // Counted on the pre-edge stall, so a flush in the same cycle does not hide it.
    cnt_d = cnt_q;
    if (stall && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
      ld_q  <= '0;
      cnt_q <= '0;
      for (int unsigned k = 1; k <= DEPTH; k++) begin
        rd_q[k] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      ld_q  <= ld_d;
      cnt_q <= cnt_d;
      for (int unsigned k = 1; k <= DEPTH; k++) begin
        rd_q[k] <= rd_d[k];
      end
    end
  end

  assign fwd_sel_a      = sel_a;
  assign fwd_sel_b      = sel_b;
  assign load_use_stall = stall;
  assign stall_count    = cnt_q;

endmodule

// File: tb/tb_forward_ctrl.sv
// Directed testbench for forward_ctrl. A default instance (CNT_W = 16) and a
// narrow-counter instance (CNT_W = 2) share all stimulus.
module tb_forward_ctrl;

  logic        clock;
  logic        reset;
  logic        flush;
  logic        dec_valid;
  logic [4:0]  dec_rd;
  logic        dec_wr_en;
  logic        dec_is_load;
  logic [4:0]  dec_rs_a;
  logic [4:0]  dec_rs_b;
  logic        dec_use_a;
  logic        dec_use_b;

  logic [1:0]  fwd_sel_a, fwd_sel_b;
  logic        load_use_stall;
  logic [15:0] stall_count;

  logic [1:0]  fwd_sel_a2, fwd_sel_b2;
  logic        load_use_stall2;
  logic [1:0]  stall_count2;

  int errors = 0;
  int checks = 0;

  forward_ctrl #(.REG_W(5), .DEPTH(3), .SEL_W(2), .CNT_W(16)) u_dut (
    .clock          (clock),
    .reset          (reset),
    .flush          (flush),
    .dec_valid      (dec_valid),
    .dec_rd         (dec_rd),
    .dec_wr_en      (dec_wr_en),
    .dec_is_load    (dec_is_load),
    .dec_rs_a       (dec_rs_a),
    .dec_rs_b       (dec_rs_b),
    .dec_use_a      (dec_use_a),
    .dec_use_b      (dec_use_b),
    .fwd_sel_a      (fwd_sel_a),
    .fwd_sel_b      (fwd_sel_b),
    .load_use_stall (load_use_stall),
    .stall_count    (stall_count)
  );

  forward_ctrl #(.REG_W(5), .DEPTH(3), .SEL_W(2), .CNT_W(2)) u_dut_small (
    .clock          (clock),
    .reset          (reset),
    .flush          (flush),
    .dec_valid      (dec_valid),
    .dec_rd         (dec_rd),
    .dec_wr_en      (dec_wr_en),
    .dec_is_load    (dec_is_load),
    .dec_rs_a       (dec_rs_a),
    .dec_rs_b       (dec_rs_b),
    .dec_use_a      (dec_use_a),
    .dec_use_b      (dec_use_b),
    .fwd_sel_a      (fwd_sel_a2),
    .fwd_sel_b      (fwd_sel_b2),
    .load_use_stall (load_use_stall2),
    .stall_count    (stall_count2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_dec(input logic v, input logic [4:0] rd, input logic wr, input logic ld,
                         input logic [4:0] rsa, input logic [4:0] rsb,
                         input logic ua, input logic ub);
    dec_valid   = v;
    dec_rd      = rd;
    dec_wr_en   = wr;
    dec_is_load = ld;
    dec_rs_a    = rsa;
    dec_rs_b    = rsb;
    dec_use_a   = ua;
    dec_use_b   = ub;
    #1;
  endtask

  // Advance one edge, leaving time 1 unit past it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    set_dec(1'b1, 5'd0, 1'b0, 1'b0, 5'd3, 5'd0, 1'b1, 1'b0);
    tick();
    tick();
    chk("rst_sel_a", 32'(fwd_sel_a), 32'd0);
    chk("rst_stall", 32'(load_use_stall), 32'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_sel_a", 32'(fwd_sel_a), 32'd0);
    chk("post_rst_sel_b", 32'(fwd_sel_b), 32'd0);
    chk("post_rst_stall", 32'(load_use_stall), 32'd0);
    chk("post_rst_count", 32'(stall_count), 32'd0);

    // ALU writer r5, then reader of r5 walks the bypass stages out.
    set_dec(1'b1, 5'd5, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
    tick();
    set_dec(1'b1, 5'd0, 1'b0, 1'b0, 5'd5, 5'd5, 1'b1, 1'b1);
    chk("r5_s1_a", 32'(fwd_sel_a), 32'd1);
    chk("r5_s1_b", 32'(fwd_sel_b), 32'd1);
    chk("r5_s1_stall", 32'(load_use_stall), 32'd0);
    tick();
    chk("r5_s2_a", 32'(fwd_sel_a), 32'd2);
    chk("r5_s2_b", 32'(fwd_sel_b), 32'd2);
    tick();
    chk("r5_s3_a", 32'(fwd_sel_a), 32'd3);
    tick();
    chk("r5_gone_a", 32'(fwd_sel_a), 32'd0);
    chk("r5_gone_b", 32'(fwd_sel_b), 32'd0);
    tick();

    // Two writers of r7: youngest wins.
    set_dec(1'b1, 5'd7, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
    tick();
    tick();
    set_dec(1'b1, 5'd0, 1'b0, 1'b0, 5'd7, 5'd0, 1'b1, 1'b0);
    chk("r7_youngest", 32'(fwd_sel_a), 32'd1);
    // Decode not valid: no forwarding.
    set_dec(1'b0, 5'd0, 1'b0, 1'b0, 5'd7, 5'd0, 1'b1, 1'b0);
    chk("r7_dec_invalid", 32'(fwd_sel_a), 32'd0);
    tick();

    // Load r4, then instruction reading r4 (B) and r6 (A) and writing r6.
    set_dec(1'b1, 5'd4, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0);
    tick();
    set_dec(1'b1, 5'd6, 1'b1, 1'b0, 5'd6, 5'd4, 1'b1, 1'b1);
    chk("lu_stall", 32'(load_use_stall), 32'd1);
    chk("lu_sel_b_s1", 32'(fwd_sel_b), 32'd1);
    chk("lu_sel_a", 32'(fwd_sel_a), 32'd0);
    chk("lu_count0", 32'(stall_count), 32'd0);
    tick();
    chk("lu_stall_drop", 32'(load_use_stall), 32'd0);
    chk("lu_sel_b_s2", 32'(fwd_sel_b), 32'd2);
    chk("lu_bubble_a", 32'(fwd_sel_a), 32'd0);
    chk("lu_count1", 32'(stall_count), 32'd1);
    tick();
    chk("lu_reissue_a", 32'(fwd_sel_a), 32'd1);
    chk("lu_sel_b_s3", 32'(fwd_sel_b), 32'd3);
    chk("lu_count_hold", 32'(stall_count), 32'd1);

    // Register 0: load to r0 never stalls or forwards.
    set_dec(1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0);
    tick();
    set_dec(1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b1);
    chk("r0_sel_a", 32'(fwd_sel_a), 32'd0);
    chk("r0_sel_b", 32'(fwd_sel_b), 32'd0);
    chk("r0_stall", 32'(load_use_stall), 32'd0);
    tick();

    // Writer r9, then flush, then reader of r9.
    set_dec(1'b1, 5'd9, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
    tick();
    set_dec(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    set_dec(1'b1, 5'd0, 1'b0, 1'b0, 5'd9, 5'd9, 1'b1, 1'b1);
    chk("flush_sel_a", 32'(fwd_sel_a), 32'd0);
    chk("flush_sel_b", 32'(fwd_sel_b), 32'd0);
    tick();

    // Flush together with a stall: state cleared, stall still counted.
    set_dec(1'b1, 5'd4, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0);
    tick();
    set_dec(1'b1, 5'd0, 1'b0, 1'b0, 5'd4, 5'd0, 1'b1, 1'b0);
    chk("fs_stall", 32'(load_use_stall), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    chk("fs_sel_a", 32'(fwd_sel_a), 32'd0);
    chk("fs_stall_drop", 32'(load_use_stall), 32'd0);
    chk("fs_count", 32'(stall_count), 32'd2);

    // Saturation of the 2-bit counter over four separate load-use stalls.
    reset = 1'b1;
    #1;
    chk("sat_rst_small", 32'(stall_count2), 32'd0);
    chk("sat_rst_big", 32'(stall_count), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_dec(1'b1, 5'd4, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0);
      tick();
      set_dec(1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 5'd4, 1'b0, 1'b1);
      chk($sformatf("sat_stall_%0d", i), 32'(load_use_stall2), 32'd1);
      tick();
      chk($sformatf("sat_small_%0d", i), 32'(stall_count2), (i < 3) ? 32'(i + 1) : 32'd3);
      chk($sformatf("sat_big_%0d", i), 32'(stall_count), 32'(i + 1));
    end

    // Reset in the middle of a stall clears everything immediately.
    set_dec(1'b1, 5'd4, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0);
    tick();
    set_dec(1'b1, 5'd0, 1'b0, 1'b0, 5'd4, 5'd0, 1'b1, 1'b0);
    chk("mid_stall_pre", 32'(load_use_stall2), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_stall_drop", 32'(load_use_stall2), 32'd0);
    chk("mid_stall_drop_big", 32'(load_use_stall), 32'd0);
    chk("mid_count_small", 32'(stall_count2), 32'd0);
    chk("mid_count_big", 32'(stall_count), 32'd0);
    chk("mid_sel_a", 32'(fwd_sel_a), 32'd0);
    reset = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
